// File: rtl/fetch_queue_ifu.sv
// Instruction fetch unit: credit-limited memory requests feeding an in-order
// {pc, inst} queue toward decode, with redirect flush and stale-response squash.
module fetch_queue_ifu #(
  parameter int                XLEN     = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QD_C   = CW'(QDEPTH);
  localparam logic [CW:0]   QD_C_W = (CW+1)'(QDEPTH);

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] rsp_pc_reg;
  logic [CW-1:0]   pending_reg;
  logic [CW-1:0]   drop_reg;
  logic [CW-1:0]   count_reg;
  logic [PW-1:0]   head_reg;
  logic [PW-1:0]   tail_reg;

  logic [XLEN-1:0] pc_mem   [QDEPTH];
  logic [XLEN-1:0] inst_mem [QDEPTH];

  logic [CW:0]     credit_used;
  logic            issue;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_target;

  // Every live outstanding request already owns a queue slot, so responses never need back-pressure.
  assign credit_used = {1'b0, count_reg} + {1'b0, pending_reg} - {1'b0, drop_reg};

  assign imem_req_valid = !rst && !redirect_valid
                          && (pending_reg < QD_C) && (credit_used < QD_C_W);
  assign imem_req_addr  = fetch_pc_reg;

  assign issue = imem_req_valid && imem_req_ready;
  assign push  = !rst && !redirect_valid && imem_rsp_valid && (drop_reg == '0);
  assign pop   = out_valid && out_ready;

  assign redirect_target = redirect_pc & ~XLEN'(3);

  assign out_valid = !rst && (count_reg != '0);
  assign out_pc    = out_valid ? pc_mem[head_reg]   : '0;
  assign out_inst  = out_valid ? inst_mem[head_reg] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      pending_reg  <= '0;
      drop_reg     <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path; a response in this cycle is already gone.
      fetch_pc_reg <= redirect_target;
      rsp_pc_reg   <= redirect_target;
      pending_reg  <= pending_reg - CW'(imem_rsp_valid);
      drop_reg     <= pending_reg - CW'(imem_rsp_valid);
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      if (issue) begin
        fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
      end
      if (push) begin
        rsp_pc_reg <= rsp_pc_reg + XLEN'(4);
        tail_reg   <= tail_reg + PW'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PW'(1);
      end
      if (imem_rsp_valid && (drop_reg != '0)) begin
        drop_reg <= drop_reg - CW'(1);
      end
      count_reg   <= count_reg + CW'(push) - CW'(pop);
      pending_reg <= pending_reg + CW'(issue) - CW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_reg]   <= rsp_pc_reg;
      inst_mem[tail_reg] <= imem_rsp_data;
    end
  end

endmodule

// File: doc/fetch_queue_ifu.md
# fetch_queue_ifu

Parametrised instruction fetch unit for the Yinger core. It replaces the single-cycle PC/ROM fetch with a request/response interface to instruction memory of arbitrary latency, keeps up to `QDEPTH` requests in flight, and buffers returned instructions in an in-order queue. A valid/ready handshake feeds decode. A single redirect port, driven by execute on taken branches and jumps, flushes the queue and squashes stale in-flight responses.

## Interface
- `XLEN`, 32: instruction and PC width.
- `QDEPTH`, 4: queue entries; also the maximum number of outstanding memory requests. Must be a power of two, ≥2.
- `RESET_PC`, 0: fetch address after reset. Bits [1:0] must be 0.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out XLEN: byte address of the request, word aligned.
- `imem_rsp_valid` in 1: one response word returns, in request order. Memory never back-pressures responses.
- `imem_rsp_data` in XLEN: instruction word.
- `redirect_valid` in 1: execute redirect (taken branch or jump), single-cycle pulse.
- `redirect_pc` in XLEN: new fetch target; bits [1:0] are ignored and forced to 0.
- `out_valid` out 1: queue head is valid.
- `out_ready` in 1: decode accepts the head.
- `out_inst` out XLEN: instruction at the queue head.
- `out_pc` out XLEN: PC of `out_inst`.

## Operation
- **State:**
  - `fetch_pc`: next address to request.
  - `rsp_pc`: PC of the next live response.
  - `pending`: all outstanding requests, 0..QDEPTH.
  - `drop`: outstanding responses to discard, ≤ `pending`.
  - Queue of {pc, inst} with `count`, 0..QDEPTH.
  - Live outstanding = `pending − drop`.
- **Issue:**
  - `imem_req_valid = !rst && !redirect_valid && pending < QDEPTH && (count + pending − drop) < QDEPTH`.
  - The credit rule guarantees every live response has a free queue slot, so no response ready signal is needed.
  - `imem_req_addr = fetch_pc`.
  - On a request handshake: `fetch_pc += 4`, `pending += 1`.
- **Response:**
  - Every `imem_rsp_valid` decrements `pending`.
  - If `drop > 0`, the word is discarded and `drop −= 1`.
  - Otherwise {`rsp_pc`, data} is pushed to the queue tail and `rsp_pc += 4`.
- **Dequeue:** `out_valid = (count != 0)`. On `out_valid && out_ready`, pop the head.
- **Simultaneous push, pop and issue** in one cycle are legal. `count` updates by push − pop; `pending` updates by issue − response.
- **Redirect** (`redirect_valid = 1`, highest priority):
  - `fetch_pc` ← `rsp_pc` ← {`redirect_pc`[XLEN−1:2], 2'b00}.
  - Queue cleared: `count` ← 0 next cycle.
  - `drop` ← `pending − imem_rsp_valid`. Any response arriving in the redirect cycle is discarded and also decrements `pending`.
  - No request is issued in the redirect cycle.
  - A pop handshake in the redirect cycle still completes; decode discards it on its own flush.
  - Back-to-back redirects: the last one wins; `drop` is recomputed each time from `pending`.
- **Arithmetic:** PC increments wrap modulo 2^XLEN. `count`, `pending` and `drop` are clog2(QDEPTH)+1 bits wide.

## Timing
- **During reset:**
  - `imem_req_valid = 0`, `out_valid = 0`.
  - `out_inst = 0`, `out_pc = 0`.
  - `fetch_pc = rsp_pc = RESET_PC`.
  - `count = pending = drop = 0`.
  - Responses arriving during reset are ignored.
- First request: the cycle after `rst` falls, at address `RESET_PC`.
- **Latency:** a response at edge N gives `out_valid = 1` from cycle N+1 (one-cycle queue write latency). No combinational path from `imem_rsp_*` to `out_*`.
- `imem_req_valid` depends combinationally on `redirect_valid`. There is no combinational path from `imem_req_ready` to `imem_req_valid`.
- `imem_req_valid` may drop without a handshake only because of a redirect or reset.
- Reset mid-operation clears everything. Responses belonging to pre-reset requests are the memory's responsibility and must not arrive after reset.
- Full queue (`count = QDEPTH`): no issue. A pop frees one credit; the request may issue the following cycle.

## Test plan
- **Reset and streaming:** `rst` high 2 cycles then low; memory has 1-cycle latency, always ready; `out_ready = 1`.
  - Requests go to 0x0, 0x4, 0x8, … on consecutive cycles.
  - `out_pc` = 0x0, 0x4, … with matching `out_inst`, one per cycle after a 2-cycle start.
- **Back-pressure, QDEPTH=4:** `out_ready = 0`.
  - Exactly 4 requests issue, then `imem_req_valid` stays 0 with `count = 4`.
  - Pulse `out_ready` for 1 cycle: exactly one new request at 0x10.
- **Redirect with in-flight squash:** 3-cycle latency; 3 requests outstanding; redirect to 0x103.
  - `fetch_pc = 0x100`, queue empty next cycle.
  - The 3 old responses are discarded.
  - First `out_pc` is 0x100.
- **Redirect coinciding with a response:** `pending = 2`, `imem_rsp_valid = 1` and redirect to 0x40 in the same cycle.
  - `drop = 1`; that response and the next one never appear.
  - `out_pc` 0x40 follows.
- **Back-to-back redirects:** redirect to 0x200 then 0x300 in consecutive cycles.
  - No request at 0x200 is returned to decode.
  - The output stream starts at 0x300.
- **Wrap-around:** `RESET_PC = 0xFFFF_FFF8`.
  - Requests go to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - `out_pc` follows the same sequence.
